// File: rtl/mic_pair_scheduler_pkg.sv
// Shared definitions for the microphone-pair scheduler: state encoding,
// default lag width and the lag-vector packing helper.
package mic_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_NEXT    = 3'd3;
  localparam logic [2:0] ST_PUBLISH = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_START   = ST_START,
    S_WAIT    = ST_WAIT,
    S_NEXT    = ST_NEXT,
    S_PUBLISH = ST_PUBLISH
  } mic_state_e;

  localparam int MIC_LAG_W = 6;

  // Pair k's lag occupies bits [k*lag_w +: lag_w] of every packed lag vector.
  function automatic int lag_lsb(input int pair, input int lag_w);
    return pair * lag_w;
  endfunction

endpackage

// File: rtl/mic_pair_scheduler_timer.sv
// Per-pair watchdog: cleared on load, counts while enabled, and flags the
// last allowed cycle of the window so the scheduler can give up on a pair.
module mps_timeout_timer #(
  parameter int TIMEOUT = 2097152,
  parameter int TMR_W   = 22
) (
  input  logic clk_60MHz,
  input  logic rst_n,
  input  logic load,
  input  logic cnt_en,
  output logic expire
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (cnt_en) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = cnt_en && (cnt_q == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/mic_pair_scheduler.sv
// Round-robin scheduler for the mic-pair cross-correlators: starts one pair
// at a time, collects its lag (or a timeout), and publishes a full frame.
module mic_pair_scheduler
  import mic_pkg::*;
#(
  parameter int NPAIR   = 4,
  parameter int LAG_W   = MIC_LAG_W,
  parameter int TIMEOUT = 2097152,
  parameter int TMR_W   = 22
) (
  input  logic                   clk_60MHz,
  input  logic                   rst_n,
  input  logic                   run_en,
  input  logic                   one_shot,
  output logic [NPAIR-1:0]       sub_start,
  input  logic [NPAIR-1:0]       sub_done,
  input  logic [NPAIR*LAG_W-1:0] sub_lag,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [NPAIR*LAG_W-1:0] res_lags,
  output logic [NPAIR-1:0]       res_tmo_mask,
  output logic                   busy,
  output logic [15:0]            frame_cnt
);

  localparam int IDX_W = (NPAIR > 1) ? $clog2(NPAIR) : 1;

  mic_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NPAIR*LAG_W-1:0] wlag_q, wlag_d;
  logic [NPAIR-1:0]       wmask_q, wmask_d;
  logic [NPAIR*LAG_W-1:0] res_lags_q, res_lags_d;
  logic [NPAIR-1:0]       res_mask_q, res_mask_d;
  logic                   res_valid_q, res_valid_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;

  logic tmr_load;
  logic tmr_en;
  logic tmr_expire;

  assign tmr_load = (state_q == S_START);
  assign tmr_en   = (state_q == S_WAIT);

  mps_timeout_timer #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) u_timer (
    .clk_60MHz (clk_60MHz),
    .rst_n     (rst_n),
    .load      (tmr_load),
    .cnt_en    (tmr_en),
    .expire    (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wlag_d      = wlag_q;
    wmask_d     = wmask_q;
    res_lags_d  = res_lags_q;
    res_mask_d  = res_mask_q;
    res_valid_d = res_valid_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (run_en || one_shot) begin
          state_d = S_START;
          idx_d   = '0;
          wlag_d  = '0;
          wmask_d = '0;
        end
      end

      S_START: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // The lag is only guaranteed valid alongside done, so it is taken now.
        if (sub_done[idx_q]) begin
          wlag_d[lag_lsb(int'(idx_q), LAG_W) +: LAG_W] =
            sub_lag[lag_lsb(int'(idx_q), LAG_W) +: LAG_W];
          wmask_d[idx_q] = 1'b0;
          state_d        = S_NEXT;
        end else if (tmr_expire) begin
          wlag_d[lag_lsb(int'(idx_q), LAG_W) +: LAG_W] = '0;
          wmask_d[idx_q] = 1'b1;
          state_d        = S_NEXT;
        end
      end

      S_NEXT: begin
        if (idx_q == IDX_W'(NPAIR - 1)) begin
          res_lags_d  = wlag_q;
          res_mask_d  = wmask_q;
          res_valid_d = 1'b1;
          state_d     = S_PUBLISH;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_START;
        end
      end

      S_PUBLISH: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (run_en) begin
            state_d = S_START;
            idx_d   = '0;
            wlag_d  = '0;
            wmask_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wlag_q      <= '0;
      wmask_q     <= '0;
      res_lags_q  <= '0;
      res_mask_q  <= '0;
      res_valid_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wlag_q      <= wlag_d;
      wmask_q     <= wmask_d;
      res_lags_q  <= res_lags_d;
      res_mask_q  <= res_mask_d;
      res_valid_q <= res_valid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    sub_start = '0;
    if (state_q == S_START) begin
      sub_start[idx_q] = 1'b1;
    end
  end

  assign res_valid    = res_valid_q;
  assign res_lags     = res_lags_q;
  assign res_tmo_mask = res_mask_q;
  assign busy         = (state_q != S_IDLE);
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_mic_pair_scheduler.sv
// Directed bench for mic_pair_scheduler: table of per-pair response scenarios
// plus hand-written backpressure, stray-done, reset-abort and wrap sequences.
module tb_mic_pair_scheduler;

  localparam int NPAIR   = 4;
  localparam int LAG_W   = 6;
  localparam int TIMEOUT = 64;
  localparam int TMR_W   = 22;
  localparam logic [LAG_W-1:0] FILL = 6'b010101;

  logic                   clk_60MHz = 1'b0;
  logic                   rst_n;
  logic                   run_en;
  logic                   one_shot;
  logic [NPAIR-1:0]       sub_start;
  logic [NPAIR-1:0]       sub_done;
  logic [NPAIR*LAG_W-1:0] sub_lag;
  logic                   res_valid;
  logic                   res_ready;
  logic [NPAIR*LAG_W-1:0] res_lags;
  logic [NPAIR-1:0]       res_tmo_mask;
  logic                   busy;
  logic [15:0]            frame_cnt;

  logic [NPAIR-1:0]       rsp_done;
  logic [NPAIR-1:0]       stray_done;
  logic [NPAIR*LAG_W-1:0] rsp_lag;

  assign sub_done = rsp_done | stray_done;
  assign sub_lag  = rsp_lag;

  mic_pair_scheduler #(
    .NPAIR   (NPAIR),
    .LAG_W   (LAG_W),
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) dut (
    .clk_60MHz    (clk_60MHz),
    .rst_n        (rst_n),
    .run_en       (run_en),
    .one_shot     (one_shot),
    .sub_start    (sub_start),
    .sub_done     (sub_done),
    .sub_lag      (sub_lag),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_lags     (res_lags),
    .res_tmo_mask (res_tmo_mask),
    .busy         (busy),
    .frame_cnt    (frame_cnt)
  );

  always #8 clk_60MHz = ~clk_60MHz;

  int cyc = 0;
  always @(posedge clk_60MHz) cyc <= cyc + 1;

  // Responder configuration: a pair answers dly cycles after its start pulse
  // (dly <= 0 means it never answers).
  int                      dly_cfg [NPAIR];
  logic [LAG_W-1:0]        lag_cfg [NPAIR];
  int                      cd      [NPAIR];
  int                      done_cyc[NPAIR];

  initial begin
    rsp_done = '0;
    rsp_lag  = {NPAIR{FILL}};
    for (int k = 0; k < NPAIR; k++) begin
      cd[k]       = 0;
      done_cyc[k] = 0;
    end
    forever begin
      @(negedge clk_60MHz);
      rsp_done = '0;
      rsp_lag  = {NPAIR{FILL}};
      for (int k = 0; k < NPAIR; k++) begin
        if (cd[k] > 0) begin
          cd[k]--;
          if (cd[k] == 0) begin
            rsp_done[k]                 = 1'b1;
            rsp_lag[k*LAG_W +: LAG_W]   = lag_cfg[k];
            done_cyc[k]                 = cyc;
          end
        end
        if (sub_start[k] && dly_cfg[k] > 0) cd[k] = dly_cfg[k];
      end
    end
  end

  // Start-pulse and valid-rise monitor
  logic [NPAIR-1:0] st_val[$];
  int               st_cyc[$];
  int               vrise = 0;
  logic             prev_v = 1'b0;

  initial begin
    forever begin
      @(negedge clk_60MHz);
      if (sub_start != '0) begin
        st_val.push_back(sub_start);
        st_cyc.push_back(cyc);
      end
      if (res_valid && !prev_v) vrise = cyc;
      prev_v = res_valid;
    end
  end

  typedef struct {
    int                     dly[NPAIR];
    logic [NPAIR*LAG_W-1:0] lags;
    logic [NPAIR*LAG_W-1:0] exp_lags;
    logic [NPAIR-1:0]       exp_mask;
    bit                     stray;
  } vec_t;

  vec_t        vecs[6];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_cfg(input int v);
    for (int k = 0; k < NPAIR; k++) begin
      dly_cfg[k] = vecs[v].dly[k];
      lag_cfg[k] = vecs[v].lags[k*LAG_W +: LAG_W];
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 2000 && !res_valid; i++) @(negedge clk_60MHz);
    chk({name, "_valid_seen"}, 64'(res_valid), 64'd1);
  endtask

  task automatic pulse_one_shot();
    one_shot = 1'b1;
    @(negedge clk_60MHz);
    one_shot = 1'b0;
  endtask

  // Wait for the frame, check contents, acknowledge it and check timing.
  task automatic check_frame(input string name, input int base,
                             input logic [NPAIR*LAG_W-1:0] el,
                             input logic [NPAIR-1:0] em);
    int n;
    wait_valid(name);
    chk({name, "_lags"}, 64'(res_lags), 64'(el));
    chk({name, "_mask"}, 64'(res_tmo_mask), 64'(em));
    res_ready = 1'b1;
    @(negedge clk_60MHz);
    res_ready = 1'b0;
    exp_cnt   = exp_cnt + 16'd1;
    chk({name, "_valid_drop"}, 64'(res_valid), 64'd0);
    chk({name, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_cnt));
    chk({name, "_busy_idle"}, 64'(busy), 64'(run_en));
    chk({name, "_lags_held"}, 64'(res_lags), 64'(el));
    n = st_val.size() - base;
    chk({name, "_start_count"}, 64'(n), 64'(NPAIR));
    if (n >= NPAIR) begin
      for (int k = 0; k < NPAIR; k++)
        chk($sformatf("%s_start_order%0d", name, k), 64'(st_val[base+k]), 64'(1 << k));
      for (int k = 0; k < NPAIR - 1; k++) begin
        if (!em[k]) chk($sformatf("%s_gap_done%0d", name, k), 64'(st_cyc[base+k+1] - done_cyc[k]), 64'd2);
        else        chk($sformatf("%s_gap_tmo%0d", name, k), 64'(st_cyc[base+k+1] - st_cyc[base+k]), 64'(TIMEOUT + 2));
      end
      if (!em[NPAIR-1]) chk({name, "_vrise"}, 64'(vrise - done_cyc[NPAIR-1]), 64'd2);
      else              chk({name, "_vrise_tmo"}, 64'(vrise - st_cyc[base+NPAIR-1]), 64'(TIMEOUT + 2));
    end
  endtask

  task automatic run_frame(input int v);
    int base;
    load_cfg(v);
    base = st_val.size();
    pulse_one_shot();
    if (vecs[v].stray) begin
      // Pair 0 is now waiting; a pair-3 done must not be taken for it.
      @(negedge clk_60MHz);
      stray_done = 4'b1000;
      @(negedge clk_60MHz);
      stray_done = '0;
    end
    check_frame($sformatf("vec%0d", v), base, vecs[v].exp_lags, vecs[v].exp_mask);
  endtask

  initial begin
    int bad;
    rst_n      = 1'b0;
    run_en     = 1'b0;
    one_shot   = 1'b0;
    res_ready  = 1'b0;
    stray_done = '0;
    for (int k = 0; k < NPAIR; k++) begin
      dly_cfg[k] = 0;
      lag_cfg[k] = '0;
    end

    vecs[0].dly = '{10, 10, 10, 10};
    vecs[0].lags = {6'sd9, 6'sd0, 6'sd3, -6'sd10};
    vecs[0].exp_lags = {6'sd9, 6'sd0, 6'sd3, -6'sd10};
    vecs[0].exp_mask = 4'b0000; vecs[0].stray = 1'b0;
    vecs[1].dly = '{10, 10, 0, 10};
    vecs[1].lags = {-6'sd32, 6'sd22, -6'sd7, 6'sd5};
    vecs[1].exp_lags = {-6'sd32, 6'sd0, -6'sd7, 6'sd5};
    vecs[1].exp_mask = 4'b0100; vecs[1].stray = 1'b0;
    vecs[2].dly = '{3, 64, 3, 3};
    vecs[2].lags = {-6'sd4, 6'sd4, -6'sd1, 6'sd31};
    vecs[2].exp_lags = {-6'sd4, 6'sd4, -6'sd1, 6'sd31};
    vecs[2].exp_mask = 4'b0000; vecs[2].stray = 1'b0;
    vecs[3].dly = '{0, 2, 5, 1};
    vecs[3].lags = {-6'sd31, -6'sd8, 6'sd8, 6'sd7};
    vecs[3].exp_lags = {-6'sd31, -6'sd8, 6'sd8, 6'sd0};
    vecs[3].exp_mask = 4'b0001; vecs[3].stray = 1'b0;
    vecs[4].dly = '{1, 1, 1, 65};
    vecs[4].lags = {-6'sd5, 6'sd3, 6'sd2, 6'sd1};
    vecs[4].exp_lags = {6'sd0, 6'sd3, 6'sd2, 6'sd1};
    vecs[4].exp_mask = 4'b1000; vecs[4].stray = 1'b0;
    vecs[5].dly = '{8, 4, 4, 4};
    vecs[5].lags = {-6'sd6, 6'sd6, -6'sd2, 6'sd2};
    vecs[5].exp_lags = {-6'sd6, 6'sd6, -6'sd2, 6'sd2};
    vecs[5].exp_mask = 4'b0000; vecs[5].stray = 1'b1;

    repeat (3) @(negedge clk_60MHz);
    chk("rst_sub_start", 64'(sub_start), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_lags", 64'(res_lags), 64'd0);
    chk("rst_mask", 64'(res_tmo_mask), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_60MHz);

    for (int v = 0; v < 6; v++) begin
      run_frame(v);
      repeat (3) @(negedge clk_60MHz);
    end

    // Done pulses while idle are ignored.
    stray_done = '1;
    @(negedge clk_60MHz);
    stray_done = '0;
    repeat (3) @(negedge clk_60MHz);
    chk("idle_stray_busy", 64'(busy), 64'd0);
    chk("idle_stray_lags", 64'(res_lags), 64'(vecs[5].exp_lags));
    chk("idle_stray_cnt", 64'(frame_cnt), 64'(exp_cnt));

    // Backpressure with run_en held: frame must hold, no new starts.
    load_cfg(0);
    for (int k = 0; k < NPAIR; k++) dly_cfg[k] = 3;
    run_en = 1'b1;
    wait_valid("stall");
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (!res_valid || res_lags !== vecs[0].exp_lags || res_tmo_mask !== 4'b0000 || sub_start !== '0) bad++;
      @(negedge clk_60MHz);
    end
    chk("stall_stable_cycles_bad", 64'(bad), 64'd0);
    res_ready = 1'b1;
    @(negedge clk_60MHz);
    res_ready = 1'b0;
    exp_cnt   = exp_cnt + 16'd1;
    chk("stall_restart_start0", 64'(sub_start), 64'b0001);
    chk("stall_valid_drop", 64'(res_valid), 64'd0);
    chk("stall_frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
    // Dropping run_en mid-frame still completes and publishes this frame.
    run_en = 1'b0;
    check_frame("runen_drop", st_val.size() - 1, vecs[0].exp_lags, 4'b0000);
    repeat (3) @(negedge clk_60MHz);

    // Reset while waiting on pair 2 aborts the frame.
    load_cfg(0);
    pulse_one_shot();
    for (int i = 0; i < 500 && !sub_start[2]; i++) @(negedge clk_60MHz);
    chk("abort_reached_pair2", 64'(sub_start[2]), 64'd1);
    repeat (3) @(negedge clk_60MHz);
    rst_n = 1'b0;
    #1;
    chk("abort_sub_start", 64'(sub_start), 64'd0);
    chk("abort_valid", 64'(res_valid), 64'd0);
    chk("abort_lags", 64'(res_lags), 64'd0);
    chk("abort_mask", 64'(res_tmo_mask), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_frame_cnt", 64'(frame_cnt), 64'd0);
    exp_cnt = 16'd0;
    repeat (2) @(negedge clk_60MHz);
    rst_n = 1'b1;
    repeat (15) @(negedge clk_60MHz);
    chk("abort_stays_idle", 64'(busy), 64'd0);
    run_frame(0);
    repeat (2) @(negedge clk_60MHz);

    // frame_cnt wrap from 0xFFFF
    force dut.frame_cnt_d = 16'hFFFF;
    @(posedge clk_60MHz);
    #1;
    release dut.frame_cnt_d;
    @(negedge clk_60MHz);
    chk("wrap_preload", 64'(frame_cnt), 64'hFFFF);
    exp_cnt = 16'hFFFF;
    run_frame(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got simulation still running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
